mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM-stage data-memory access unit between the EX/MEM register and mem_wb_reg.
- Turns EX/MEM load/store control into a req/ack data-memory transaction, stalling the pipeline while the transaction is in flight.
- Drives aluout1 (ALU result pass-through) and aluout2 (aligned, extended load data) into mem_wb_reg.

Parameters:
TIMEOUT_CYCLES, 16, BUSY cycles without dmem_ack before the access is abandoned (used only with DMEM_TIMEOUT_EN)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
ex_mem_ins_valid  input  1  instruction in EX/MEM is valid
ex_mem_mem_read  input  1  load
ex_mem_mem_write  input  1  store; wins if both read and write are set
ex_mem_funct3  input  3  RV32I size/sign code
ex_mem_aluout  input  32  ALU result / effective address
ex_mem_rs2_data  input  32  store data
dmem_ack  input  1  memory completes request (read data valid)
dmem_rdata  input  32  read word
dmem_req  output  1  request, registered
dmem_we  output  1  write enable, registered
dmem_addr  output  32  word address ({addr[31:2],2'b00}), registered
dmem_wdata  output  32  lane-replicated store data, registered
dmem_wstrb  output  4  byte strobes, registered
mem_stall  output  1  hold PC/IF/ID/EX/EX-MEM; combinational
mem_misaligned  output  1  one-cycle flag for a misaligned access; combinational
mem_bus_error  output  1  timeout pulse (tied 0 without DMEM_TIMEOUT_EN)
aluout1  output  32  = ex_mem_aluout; combinational
aluout2  output  32  load result in DONE, else 0

Behaviour:
- Reset values on a rst edge: state IDLE, dmem_req/dmem_we 0, dmem_addr/dmem_wdata 0, dmem_wstrb 0, load data register 0, timeout counter 0.
- While rst=1: mem_stall=0, aluout2=0, mem_misaligned=0, mem_bus_error=0.
- FSM states: IDLE, BUSY, DONE.
- mem_op is ex_mem_ins_valid & (ex_mem_mem_read | ex_mem_mem_write).
- Alignment rules: word needs addr[1:0]=0; half needs addr[0]=0; bytes are always aligned.
- IDLE, no mem_op or invalid instruction: mem_stall=0, aluout2=0, no request, stay IDLE.
- IDLE, mem_op misaligned: mem_misaligned=1, mem_stall=0, aluout2=0, no request, stay IDLE.
- IDLE, mem_op aligned: mem_stall=1. Next edge goes to BUSY and registers req=1, we, addr, wdata and wstrb.
  - SB: wdata={4{rs2[7:0]}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, wstrb=0011<<{addr[1],1'b0}.
  - SW: wdata=rs2, wstrb=1111.
  - Loads: wstrb=0000.
  - Unused funct3 codes (011, 11x) are treated as word size.
- BUSY: mem_stall=1; dmem_req and all bus outputs held stable until dmem_ack.
  - On dmem_ack: capture dmem_rdata through load_align, drop dmem_req, go to DONE.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Byte select uses addr[1:0]; half select uses addr[1].
- DONE: mem_stall=0; aluout2 = captured load data if read, 0 if store. Unconditionally to IDLE next edge (EX/MEM advances on that same edge).
- Latency: ack in the first BUSY cycle gives 3 cycles per access (IDLE, BUSY, DONE) and 2 stall cycles. Each extra wait cycle adds one stall.
- dmem_ack outside BUSY is ignored.
- Back-to-back memory ops: the second op is evaluated in the IDLE cycle after DONE. No request is issued in DONE.
- Reset mid-BUSY: on the reset edge dmem_req drops and state returns to IDLE; the transaction is abandoned.
- Upstream must hold all ex_mem_* inputs stable while mem_stall=1.

Optional Feature:
- DMEM_TIMEOUT_EN defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - On reaching TIMEOUT_CYCLES: drop dmem_req, go to DONE with aluout2=0, and assert mem_bus_error for that DONE cycle.
  - An ack on the same cycle as the limit wins (normal completion).
- DMEM_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; mem_bus_error tied 0.

Decomposition:
- Package yarc_mem_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State encoding IDLE/BUSY/DONE.
  - Strobe constants.
- One combinational sub-module, load_align: inputs rdata, addr[1:0], funct3; output 32-bit extended load value.

Test Plan:
- LW at 0x100, ack after 1 BUSY cycle, rdata=0xDEADBEEF -> dmem_addr=0x100, wstrb=0000, mem_stall high 2 cycles, aluout2=0xDEADBEEF in DONE.
- LB at 0x103, rdata=0x80FF_1234 -> aluout2=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x102 -> 0x000080FF.
- SB at 0x201, rs2=0x000000A5 -> dmem_wdata=0xA5A5A5A5, wstrb=0010, we=1, aluout2=0. SH at 0x202 -> wstrb=1100.
- LW at 0x102 -> mem_misaligned=1 for one cycle, dmem_req never asserts, mem_stall=0.
- rst asserted during the 3rd BUSY wait cycle -> dmem_req=0 and state IDLE after that edge; a late ack is ignored.
- With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> req held exactly 4 cycles, then mem_bus_error=1 and aluout2=0 for one cycle, then back to IDLE.

Source files
------------

// File: rtl/yarc_mem_pkg.sv
// Shared constants and helpers for the MEM-stage data-memory access unit:
// RV32I funct3 size codes, FSM state encoding, byte-strobe patterns.
package yarc_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_B    = 4'b0001;
    localparam logic [3:0] STRB_H    = 4'b0011;
    localparam logic [3:0] STRB_W    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Unused codes (011, 11x) fall through to word size.
    function automatic size_e access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic is_aligned(input size_e sz, input logic [1:0] addr_lo);
        case (sz)
            SZ_B:    return 1'b1;
            SZ_H:    return ~addr_lo[0];
            default: return (addr_lo == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load data alignment: selects the addressed byte/half from the read word
// and sign- or zero-extends it according to funct3.
module load_align
    import yarc_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'b00:   byte_sel = rdata[7:0];
            2'b01:   byte_sel = rdata[15:8];
            2'b10:   byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'h000000, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'h0000, half_sel};
            F3_W:    data = rdata;
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: converts EX/MEM load/store control into a
// registered req/ack transaction and stalls the pipeline while it is in flight.
// Optional bus timeout enabled by defining DMEM_TIMEOUT_EN.
module mem_access_stage
    import yarc_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_ins_valid,
    input  logic        ex_mem_mem_read,
    input  logic        ex_mem_mem_write,
    input  logic [2:0]  ex_mem_funct3,
    input  logic [31:0] ex_mem_aluout,
    input  logic [31:0] ex_mem_rs2_data,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    output logic        mem_stall,
    output logic        mem_misaligned,
    output logic        mem_bus_error,
    output logic [31:0] aluout1,
    output logic [31:0] aluout2
);

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] load_q, load_d;

    logic        mem_op;
    logic        aligned;
    size_e       sz;
    logic [31:0] load_val;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    assign mem_op  = ex_mem_ins_valid & (ex_mem_mem_read | ex_mem_mem_write);
    assign sz      = access_size(ex_mem_funct3);
    assign aligned = is_aligned(sz, ex_mem_aluout[1:0]);

    // ex_mem_* is held stable during the stall, so the live funct3/address select the lanes.
    load_align u_load_align (
        .rdata  (dmem_rdata),
        .addr   (ex_mem_aluout[1:0]),
        .funct3 (ex_mem_funct3),
        .data   (load_val)
    );

    always_comb begin
        case (sz)
            SZ_B: begin
                st_wdata = {4{ex_mem_rs2_data[7:0]}};
                st_wstrb = STRB_B << ex_mem_aluout[1:0];
            end
            SZ_H: begin
                st_wdata = {2{ex_mem_rs2_data[15:0]}};
                st_wstrb = STRB_H << {ex_mem_aluout[1], 1'b0};
            end
            default: begin
                st_wdata = ex_mem_rs2_data;
                st_wstrb = STRB_W;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        load_d  = load_q;
`ifdef DMEM_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mem_op && aligned) begin
                    state_d = ST_BUSY;
                    req_d   = 1'b1;
                    we_d    = ex_mem_mem_write;
                    addr_d  = {ex_mem_aluout[31:2], 2'b00};
                    wdata_d = st_wdata;
                    wstrb_d = ex_mem_mem_write ? st_wstrb : STRB_NONE;
`ifdef DMEM_TIMEOUT_EN
                    cnt_d     = '0;
                    timeout_d = 1'b0;
`endif
                end
            end
            ST_BUSY: begin
                if (dmem_ack) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    load_d  = load_val;
                end
`ifdef DMEM_TIMEOUT_EN
                // An ack arriving on the limit cycle takes priority over the timeout.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = ST_DONE;
                    req_d     = 1'b0;
                    load_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            load_q  <= '0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            load_q  <= load_d;
`ifdef DMEM_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_wstrb = wstrb_q;

    assign mem_stall      = ~rst & ((state_q == ST_BUSY) |
                                    ((state_q == ST_IDLE) & mem_op & aligned));
    assign mem_misaligned = ~rst & (state_q == ST_IDLE) & mem_op & ~aligned;
    assign aluout1        = ex_mem_aluout;
    assign aluout2        = (~rst && state_q == ST_DONE && !we_q) ? load_q : 32'h0;

`ifdef DMEM_TIMEOUT_EN
    assign mem_bus_error = ~rst & (state_q == ST_DONE) & timeout_q;
`else
    assign mem_bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized
// loads/stores against a byte-lane reference model. Honors DMEM_TIMEOUT_EN.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_mem_ins_valid;
    logic        ex_mem_mem_read;
    logic        ex_mem_mem_write;
    logic [2:0]  ex_mem_funct3;
    logic [31:0] ex_mem_aluout;
    logic [31:0] ex_mem_rs2_data;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        mem_stall;
    logic        mem_misaligned;
    logic        mem_bus_error;
    logic [31:0] aluout1;
    logic [31:0] aluout2;

    int tests_run = 0;
    int tests_failed = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_mem_ins_valid (ex_mem_ins_valid),
        .ex_mem_mem_read  (ex_mem_mem_read),
        .ex_mem_mem_write (ex_mem_mem_write),
        .ex_mem_funct3    (ex_mem_funct3),
        .ex_mem_aluout    (ex_mem_aluout),
        .ex_mem_rs2_data  (ex_mem_rs2_data),
        .dmem_ack         (dmem_ack),
        .dmem_rdata       (dmem_rdata),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_wstrb       (dmem_wstrb),
        .mem_stall        (mem_stall),
        .mem_misaligned   (mem_misaligned),
        .mem_bus_error    (mem_bus_error),
        .aluout1          (aluout1),
        .aluout2          (aluout2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running exp finished");
        $fatal(1, "watchdog");
    end

    // Reference model: size in bytes from funct3, lane math by plain arithmetic.
    function automatic int model_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int sz;
        logic [31:0] v;
        sz = model_size(f3);
        v  = rdata >> (8 * (addr % 4));
        if (sz == 1) begin
            v = v % 256;
            if (!f3[2] && v >= 128) v = v - 256;
        end else if (sz == 2) begin
            v = v % 65536;
            if (!f3[2] && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] rs2,
                             input int dly, input logic [31:0] rdata);
        int          sz;
        logic        ok;
        logic [31:0] e_addr, e_wdata, e_load;
        logic [3:0]  e_strb;
        int          stalls;
        sz      = model_size(f3);
        ok      = (addr % sz) == 0;
        e_addr  = addr - (addr % 4);
        e_wdata = (sz == 1) ? (rs2 % 256) * 32'h0101_0101 :
                  (sz == 2) ? (rs2 % 65536) * 32'h0001_0001 : rs2;
        e_strb  = wr ? 4'(((1 << sz) - 1) << (addr % 4)) : 4'b0000;
        e_load  = wr ? 32'h0 : model_load(f3, addr, rdata);

        @(negedge clk);
        ex_mem_ins_valid = 1'b1;
        ex_mem_mem_read  = rd;
        ex_mem_mem_write = wr;
        ex_mem_funct3    = f3;
        ex_mem_aluout    = addr;
        ex_mem_rs2_data  = rs2;
        dmem_ack         = 1'b0;
        #1;
        tests_run++;
        if (aluout1 !== addr) begin
            tests_failed++;
            $display("FAIL aluout1 got %h exp %h", aluout1, addr);
        end
        if (!ok) begin
            tests_run++;
            if ({mem_misaligned, mem_stall, dmem_req, aluout2} !== {3'b100, 32'h0}) begin
                tests_failed++;
                $display("FAIL misaligned_flag addr=%h got mis=%b stall=%b req=%b a2=%h exp 1 0 0 0",
                         addr, mem_misaligned, mem_stall, dmem_req, aluout2);
            end
            @(negedge clk);
            ex_mem_ins_valid = 1'b0;
            #1;
            tests_run++;
            if ({mem_misaligned, mem_stall, dmem_req} !== 3'b000) begin
                tests_failed++;
                $display("FAIL misaligned_after got mis=%b stall=%b req=%b exp 000",
                         mem_misaligned, mem_stall, dmem_req);
            end
            return;
        end
        tests_run++;
        if ({mem_misaligned, mem_stall, dmem_req} !== 3'b010) begin
            tests_failed++;
            $display("FAIL idle_accept got mis=%b stall=%b req=%b exp 010",
                     mem_misaligned, mem_stall, dmem_req);
        end
        stalls = int'(mem_stall);
        for (int c = 0; c <= dly; c++) begin
            @(negedge clk);
            dmem_ack   = (c == dly);
            dmem_rdata = (c == dly) ? rdata : $urandom;
            #1;
            stalls += int'(mem_stall);
            tests_run++;
            if (wr) begin
                if ({dmem_req, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata} !==
                    {1'b1, 1'b1, e_strb, e_addr, e_wdata}) begin
                    tests_failed++;
                    $display("FAIL store_bus got req=%b we=%b strb=%b addr=%h wdata=%h exp 1 1 %b %h %h",
                             dmem_req, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata, e_strb, e_addr, e_wdata);
                end
            end else begin
                if ({dmem_req, dmem_we, dmem_wstrb, dmem_addr} !== {1'b1, 1'b0, 4'b0000, e_addr}) begin
                    tests_failed++;
                    $display("FAIL load_bus got req=%b we=%b strb=%b addr=%h exp 1 0 0000 %h",
                             dmem_req, dmem_we, dmem_wstrb, dmem_addr, e_addr);
                end
            end
        end
        @(negedge clk);
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        #1;
        tests_run++;
        if ({mem_stall, dmem_req, mem_bus_error, aluout2} !== {3'b000, e_load}) begin
            tests_failed++;
            $display("FAIL done f3=%b addr=%h got stall=%b req=%b err=%b a2=%h exp 0 0 0 %h",
                     f3, addr, mem_stall, dmem_req, mem_bus_error, aluout2, e_load);
        end
        tests_run++;
        if (stalls !== dly + 2) begin
            tests_failed++;
            $display("FAIL stall_cycles got %0d exp %0d", stalls, dly + 2);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        dmem_ack         = 1'($urandom_range(0, 1));
        ex_mem_ins_valid = 1'($urandom_range(0, 1));
        ex_mem_mem_read  = ex_mem_ins_valid ? 1'b0 : 1'($urandom_range(0, 1));
        ex_mem_mem_write = ex_mem_ins_valid ? 1'b0 : 1'($urandom_range(0, 1));
        ex_mem_aluout    = $urandom;
        #1;
        tests_run++;
        if ({mem_stall, mem_misaligned, dmem_req, aluout2} !== {3'b000, 32'h0}) begin
            tests_failed++;
            $display("FAIL no_op got stall=%b mis=%b req=%b a2=%h exp 0 0 0 0",
                     mem_stall, mem_misaligned, dmem_req, aluout2);
        end
        ex_mem_ins_valid = 1'b0;
        dmem_ack         = 1'b0;
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        ex_mem_ins_valid = 1'b1;
        ex_mem_mem_read  = 1'b1;
        ex_mem_mem_write = 1'b0;
        ex_mem_funct3    = 3'b010;
        ex_mem_aluout    = 32'h0000_0100;
        ex_mem_rs2_data  = 32'h1234_5678;
        dmem_ack         = 1'b0;
        dmem_rdata       = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if ({mem_stall, mem_misaligned, mem_bus_error, aluout2} !== {3'b000, 32'h0}) begin
            tests_failed++;
            $display("FAIL reset_comb got stall=%b mis=%b err=%b a2=%h exp 0 0 0 0",
                     mem_stall, mem_misaligned, mem_bus_error, aluout2);
        end
        tests_run++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb} !== 70'h0) begin
            tests_failed++;
            $display("FAIL reset_regs got req=%b we=%b addr=%h wdata=%h strb=%b exp all zero",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb);
        end
        @(negedge clk);
        rst              = 1'b0;
        ex_mem_ins_valid = 1'b0;
    endtask

    task automatic test_plan_vectors();
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF);
        idle_cycle();
        do_access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 1, 32'h80FF_1234);
        do_access(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 32'h80FF_1234);
        do_access(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 2, 32'h80FF_1234);
        do_access(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 0, 32'h80FF_1234);
        do_access(1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 0, 32'h0);
        do_access(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hCAFE_BABE, 1, 32'h0);
        do_access(1'b1, 1'b1, 3'b010, 32'h0000_0204, 32'h0BAD_F00D, 0, 32'hFFFF_FFFF);
    endtask

    task automatic test_misaligned();
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 0, 32'h0);
        do_access(1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'h0, 0, 32'h0);
        do_access(1'b1, 1'b0, 3'b110, 32'h0000_0301, 32'h0, 0, 32'h0);
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'h1122_3344, 0, 32'h0);
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 0, 32'h1122_3344);
        do_access(1'b1, 1'b0, 3'b011, 32'h0000_0404, 32'h0, 3, 32'h5566_7788);
        do_access(1'b0, 1'b1, 3'b000, 32'h0000_0407, 32'h0000_00C3, 2, 32'h0);
    endtask

    task automatic test_random();
        logic [2:0] f3;
        logic       rd, wr;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                idle_cycle();
            end else begin
                f3 = 3'($urandom_range(0, 7));
                wr = 1'($urandom_range(0, 1));
                rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
                do_access(rd, wr, f3, $urandom, $urandom, $urandom_range(0, 3), $urandom);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        ex_mem_ins_valid = 1'b1;
        ex_mem_mem_read  = 1'b1;
        ex_mem_mem_write = 1'b0;
        ex_mem_funct3    = 3'b010;
        ex_mem_aluout    = 32'h0000_0300;
        dmem_ack         = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if ({mem_stall, mem_misaligned, aluout2} !== {2'b00, 32'h0}) begin
            tests_failed++;
            $display("FAIL rst_busy_comb got stall=%b mis=%b a2=%h exp 0 0 0",
                     mem_stall, mem_misaligned, aluout2);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (dmem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_busy_req got %b exp 0", dmem_req);
        end
        rst              = 1'b0;
        ex_mem_ins_valid = 1'b0;
        dmem_ack         = 1'b1;
        dmem_rdata       = 32'hFFFF_FFFF;
        @(negedge clk);
        #1;
        tests_run++;
        if ({dmem_req, mem_stall, aluout2} !== {2'b00, 32'h0}) begin
            tests_failed++;
            $display("FAIL late_ack got req=%b stall=%b a2=%h exp 0 0 0",
                     dmem_req, mem_stall, aluout2);
        end
        dmem_ack = 1'b0;
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        int req_cycles;
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 3, 32'h0F0F_0F0F);
        @(negedge clk);
        ex_mem_ins_valid = 1'b1;
        ex_mem_mem_read  = 1'b1;
        ex_mem_mem_write = 1'b0;
        ex_mem_funct3    = 3'b010;
        ex_mem_aluout    = 32'h0000_0600;
        dmem_ack         = 1'b0;
        req_cycles       = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (!dmem_req) break;
            req_cycles++;
        end
        tests_run++;
        if (req_cycles !== 4) begin
            tests_failed++;
            $display("FAIL timeout_req_cycles got %0d exp 4", req_cycles);
        end
        tests_run++;
        if ({mem_bus_error, mem_stall, aluout2} !== {2'b10, 32'h0}) begin
            tests_failed++;
            $display("FAIL timeout_done got err=%b stall=%b a2=%h exp 1 0 0",
                     mem_bus_error, mem_stall, aluout2);
        end
        @(negedge clk);
        ex_mem_ins_valid = 1'b0;
        #1;
        tests_run++;
        if ({mem_bus_error, dmem_req} !== 2'b00) begin
            tests_failed++;
            $display("FAIL timeout_after got err=%b req=%b exp 0 0", mem_bus_error, dmem_req);
        end
    endtask
`else
    task automatic test_long_wait();
        do_access(1'b1, 1'b0, 3'b001, 32'h0000_0702, 32'h0, 20, 32'h8001_0000);
    endtask
`endif

    initial begin
        test_reset();
        test_plan_vectors();
        test_misaligned();
        test_back_to_back();
        test_random();
        test_reset_mid_busy();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        idle_cycle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
